// File: rtl/sram_pkt_reader.sv
// Descriptor-driven SRAM read initiator: one read per cycle under a credit limit,
// with a 2-entry buffer absorbing the one-cycle read latency and valid/ready output.
module sram_pkt_reader #(
    parameter int DWIDTH    = 32,
    parameter int NRAMWIDTH = 5,
    parameter int AWIDTH    = 13,
    parameter int LWIDTH    = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          desc_valid_in,
    output logic                          desc_ready_out,
    input  logic [NRAMWIDTH+AWIDTH-1:0]   desc_addr_in,
    input  logic [LWIDTH-1:0]             desc_len_in,
    output logic                          mem_en_out,
    output logic                          mem_we_out,
    output logic [NRAMWIDTH+AWIDTH-1:0]   mem_addr_out,
    input  logic [DWIDTH-1:0]             mem_d_in,
    output logic                          dout_valid_out,
    input  logic                          dout_ready_in,
    output logic [DWIDTH-1:0]             dout_data_out,
    output logic                          dout_last_out,
    output logic                          busy_out,
    output logic                          done_out
);
    localparam int FAW = NRAMWIDTH + AWIDTH;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    typedef struct packed {
        logic              last;
        logic [DWIDTH-1:0] data;
    } entry_t;

    state_t             state_q;
    logic [FAW-1:0]     rd_addr_q;
    logic [LWIDTH-1:0]  rd_cnt_q;
    logic               infl_q, infl_last_q;
    entry_t             buf_q [2];
    logic               wr_ptr_q, rd_ptr_q;
    logic [1:0]         occ_q, occ_d;
    logic               done_q;

    entry_t head;
    logic   pop, issue;

    assign head  = buf_q[rd_ptr_q];
    assign pop   = (occ_q != 2'd0) && dout_ready_in;
    // Credit: words held plus word in flight, after this cycle's pop, must leave room.
    assign issue = (state_q == READ) &&
                   (({1'b0, occ_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        occ_d = occ_q + {1'b0, infl_q} - {1'b0, pop};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            rd_cnt_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= pop && head.last;
            infl_q      <= issue;
            infl_last_q <= issue && (rd_cnt_q == '0);
            occ_q       <= occ_d;
            if (issue) begin
                rd_addr_q <= rd_addr_q + FAW'(1);
                rd_cnt_q  <= rd_cnt_q - LWIDTH'(1);
            end
            if (infl_q) begin
                buf_q[wr_ptr_q] <= '{last: infl_last_q, data: mem_d_in};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
            case (state_q)
                IDLE: if (desc_valid_in) begin
                    rd_addr_q <= desc_addr_in;
                    rd_cnt_q  <= desc_len_in;
                    state_q   <= READ;
                end
                READ: if (issue && rd_cnt_q == '0)
                    state_q <= DRAIN;
                DRAIN: if (pop && head.last)
                    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign desc_ready_out = (state_q == IDLE);
    assign busy_out       = (state_q != IDLE);
    assign mem_en_out     = issue;
    assign mem_we_out     = 1'b0;
    assign mem_addr_out   = rd_addr_q;
    assign dout_valid_out = (occ_q != 2'd0);
    assign dout_data_out  = head.data;
    assign dout_last_out  = head.last;
    assign done_out       = done_q;
endmodule
